// File: rtl/up_down.sv
// up_down: synchronous up/down counter built from per-bit T flip-flops.
// t enables counting, c selects direction (0 = up, 1 = down); q is registered.
module up_down #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             t,
    input  logic             c,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] toggle;
    logic             lower_ones;
    logic             lower_zeros;

    // Per-bit toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        toggle      = '0;
        lower_ones  = 1'b1;
        lower_zeros = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            toggle[i]   = t & (c ? lower_zeros : lower_ones);
            lower_ones  = lower_ones & q[i];
            lower_zeros = lower_zeros & ~q[i];
        end
    end

    // T flip-flop bank, all bits on clk; asynchronous clear while reset is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q ^ toggle;
        end
    end

endmodule

// File: tb/tb_up_down.sv
// tb_up_down: scoreboard bench for up_down. Stimulus pushes the expected next
// count for every rising edge; a monitor pops and compares after each edge.
module tb_up_down;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned MODV  = 1 << WIDTH;

    logic             t;
    logic             c;
    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] q;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned model  = 0;
    int unsigned exp_q[$];

    up_down #(.WIDTH(WIDTH)) dut (
        .t     (t),
        .c     (c),
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got q=%0d required end of test", q);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: after each rising edge, compare q with the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check("q_after_edge", int'(q), exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus driven at the falling edge; the reference model
    // advances with plain modular arithmetic and the result is queued.
    task automatic step(input logic r, input logic tv, input logic cv);
        @(negedge clk);
        reset = r;
        t     = tv;
        c     = cv;
        if (r) begin
            model = 0;
            #1;
            check("reset_level_async", int'(q), 0);
        end else if (tv) begin
            model = cv ? (model + MODV - 1) % MODV : (model + 1) % MODV;
        end
        exp_q.push_back(model);
    endtask

    task automatic count_to(input int unsigned target, input logic cv);
        int unsigned n = 0;
        while (model != target && n < 2 * MODV) begin
            step(1'b0, 1'b1, cv);
            n++;
        end
        check("count_to_target", model, target);
    endtask

    initial begin
        reset = 1'b1;
        t     = 1'b1;
        c     = 1'b0;
        #1;
        check("reset_at_start", int'(q), 0);
        #3;
        check("reset_held", int'(q), 0);

        // Count up from reset through the wrap: 1..7, 0, 1.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);

        // Reach 7 and wrap to 0, then 1.
        count_to(7, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Count down from 0: 7, 6, ..., 0, 7.
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1);

        // Hold at 4 for three edges with c toggling, then resume up.
        step(1'b1, 1'b0, 1'b0);
        count_to(4, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        // Direction change mid-count takes effect immediately.
        step(1'b1, 1'b0, 1'b0);
        count_to(3, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        // Asynchronous reset between edges at q=5.
        count_to(5, 1'b0);
        @(negedge clk);
        #2;
        check("pre_async_reset", int'(q), 5);
        reset = 1'b1;
        model = 0;
        #1;
        check("async_reset_mid_cycle", int'(q), 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom));
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_down.md
UP_DOWN -- requirements
Module: up_down

Interface
REQ-001 The module SHALL be named up_down, with positional port order t, c, clk, reset, q.
REQ-002 Parameter WIDTH SHALL default to 3 and set the counter width.
REQ-003 Port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state changes occur on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, and act as an asynchronous, active-high reset.
REQ-005 Port t SHALL be an input, 1 bit wide, and act as the count/toggle enable (1 = count, 0 = hold).
REQ-006 Port c SHALL be an input, 1 bit wide, and select direction (0 = up, 1 = down).
REQ-007 Port q SHALL be an output, WIDTH bits wide, and carry the current count value (registered).

Function
REQ-008 The design SHALL be one clock domain (clk) with an asynchronous, active-high reset (reset).
REQ-009 On each rising clk edge with reset low and t=1, c=0: q SHALL become (q+1) mod 2^WIDTH.
REQ-010 On each rising clk edge with reset low and t=1, c=1: q SHALL become (q-1) mod 2^WIDTH.
REQ-011 On a rising clk edge with reset low and t=0, q SHALL hold its value regardless of c.
REQ-012 Latency SHALL be one clock: q reflects the t/c values sampled at the same rising edge, with no pipeline.
REQ-013 Counting up, 7 SHALL wrap to 0 (for WIDTH=3), with no flag or stall.
REQ-014 Counting down, 0 SHALL wrap to 7 (for WIDTH=3), with no flag or stall.
REQ-015 A change of c mid-count SHALL take effect at the next rising edge, with no extra idle cycle.
REQ-016 Each bit q[i] SHALL behave as a T flip-flop.
  - Toggle condition, up: t AND all lower bits q[i-1:0] = 1.
  - Toggle condition, down: t AND all lower bits = 0.
  - q[0] toggles whenever t=1.
  - The implementation SHALL be synchronous: all bits clocked by clk, with no ripple clocking.
REQ-017 The output q SHALL be driven directly from flops, with no combinational path from t or c to q.

Reset
REQ-018 While reset=1, q SHALL be 0 immediately, without waiting for a clock edge, and SHALL stay 0 regardless of clk, t or c.
REQ-019 Reset assertion mid-count SHALL clear q asynchronously; counting resumes from 0.
REQ-020 After reset deasserts, the first rising clk edge with reset low SHALL apply REQ-009 to REQ-011.
  - If reset falls at the same instant as a clk rising edge, that edge is treated as occurring while reset is still asserted, so q stays 0.
REQ-021 No output SHALL be X after reset has been asserted once.

Verification
REQ-022 Reset=1 for 5 time units with t=1, c=0, clk period 10 -> q=0 throughout reset; then q = 1, 2, 3, ..., 7, 0, 1 on successive rising edges.
REQ-023 Preload q=7 by counting up, keep t=1, c=0 -> q=0 at next edge (wrap), then 1.
REQ-024 From reset (q=0), t=1, c=1 -> q = 7, 6, 5, ..., 0, 7 on successive edges.
REQ-025 Count up to q=4, then t=0 for 3 edges with c toggling -> q remains 4; re-enable t=1, c=0 -> q=5.
REQ-026 Count up to q=3, set c=1 -> q=2 at next edge; set c=0 -> q=3 at the following edge.
REQ-027 Assert reset between clock edges at q=5 -> q=0 before the next edge; hold reset across 2 edges -> q stays 0; release with t=1, c=0 -> q=1 at the next edge.
